// File: rtl/adder_pkg.sv
// Shared definitions for the wide-adder benchmark front end.
// Holds the default widths, the words-per-operand helper and the loader states.
package adder_pkg;

    localparam int ADDER_WIDTH_DEF = 109;
    localparam int WORD_WIDTH_DEF  = 16;

    // Ceiling division: number of words needed to cover an operand.
    function automatic int nwords(input int width, input int word);
        return (width + word - 1) / word;
    endfunction

    // Counter width for n words; at least one bit, even when n is 1.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } loader_state_e;

endpackage

// File: rtl/adder_operand_loader_if.sv
// Word-stream input and operand-pair output bundle of the operand loader.
// The slave side is the loader; the master side is whoever feeds and drains it.
interface adder_operand_loader_if
    import adder_pkg::*;
#(
    parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
    parameter int WORD_WIDTH  = WORD_WIDTH_DEF
);
    logic                   flush;
    logic [WORD_WIDTH-1:0]  in_word;
    logic                   in_valid;
    logic                   in_ready;
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic                   out_valid;
    logic                   out_ready;
    logic                   trunc_err;

    modport slave (
        input  flush, in_word, in_valid, out_ready,
        output in_ready, a, b, out_valid, trunc_err
    );

    modport master (
        output flush, in_word, in_valid, out_ready,
        input  in_ready, a, b, out_valid, trunc_err
    );
endinterface

// File: rtl/adder_operand_loader_packer.sv
// One operand register built from word-wide slices; the top slice is clipped to
// the operand width, and drop_nz flags input bits that clipping would discard.
module operand_word_packer
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH_DEF,
    parameter int WORD_W = WORD_WIDTH_DEF,
    localparam int NW    = nwords(WIDTH, WORD_W),
    localparam int IDX_W = idx_bits(NW)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] word,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    output logic [WIDTH-1:0]  value,
    output logic              drop_nz
);
    localparam int TAIL = WIDTH - (NW - 1) * WORD_W;

    for (genvar k = 0; k < NW; k++) begin : g_slice
        localparam int LO = k * WORD_W;
        localparam int SW = (WIDTH - LO < WORD_W) ? (WIDTH - LO) : WORD_W;

        logic [SW-1:0] slice_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                slice_q <= '0;
            else if (we && idx == IDX_W'(k))
                slice_q <= word[SW-1:0];
        end

        assign value[LO +: SW] = slice_q;
    end

    // Only a partially used final slice can lose bits.
    if (TAIL == WORD_W) begin : g_exact
        assign drop_nz = 1'b0;
    end else begin : g_clip
        assign drop_nz = |word[WORD_W-1:TAIL];
    end

endmodule

// File: rtl/adder_operand_loader.sv
// Assembles operands A then B from a LSW-first word stream and hands the pair
// to the adder with valid/ready; no skid, so input stalls while presenting.
module adder_operand_loader
    import adder_pkg::*;
#(
    parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
    parameter int WORD_WIDTH  = WORD_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_operand_loader_if.slave bus
);
    localparam int NWORDS = nwords(ADDER_WIDTH, WORD_WIDTH);
    localparam int IDX_W  = idx_bits(NWORDS);

    loader_state_e    state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             trunc_q, trunc_d;
    logic             accept, last, we_a, we_b;
    logic             drop_a, drop_b, drop_hit;
    logic [ADDER_WIDTH-1:0] a_val, b_val;

    assign bus.in_ready  = (state_q != PRESENT);
    assign bus.out_valid = (state_q == PRESENT);
    assign bus.a         = a_val;
    assign bus.b         = b_val;
    assign bus.trunc_err = trunc_q;

    assign accept   = bus.in_valid & bus.in_ready;
    assign last     = (cnt_q == IDX_W'(NWORDS - 1));
    // A word arriving alongside flush must not land in either operand.
    assign we_a     = accept & ~bus.flush & (state_q == LOAD_A);
    assign we_b     = accept & ~bus.flush & (state_q == LOAD_B);
    assign drop_hit = (state_q == LOAD_A) ? drop_a : drop_b;

    operand_word_packer #(.WIDTH(ADDER_WIDTH), .WORD_W(WORD_WIDTH)) u_pack_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .word    (bus.in_word),
        .we      (we_a),
        .idx     (cnt_q),
        .value   (a_val),
        .drop_nz (drop_a)
    );

    operand_word_packer #(.WIDTH(ADDER_WIDTH), .WORD_W(WORD_WIDTH)) u_pack_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .word    (bus.in_word),
        .we      (we_b),
        .idx     (cnt_q),
        .value   (b_val),
        .drop_nz (drop_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trunc_d = trunc_q;
        if (bus.flush) begin
            state_d = LOAD_A;
            cnt_d   = '0;
            trunc_d = 1'b0;
        end else begin
            if (accept) begin
                cnt_d = last ? '0 : cnt_q + IDX_W'(1);
                if (last && drop_hit)
                    trunc_d = 1'b1;
            end
            case (state_q)
                LOAD_A:  if (accept && last) state_d = LOAD_B;
                LOAD_B:  if (accept && last) state_d = PRESENT;
                PRESENT: if (bus.out_ready)  state_d = LOAD_A;
                default: state_d = LOAD_A;
            endcase
        end
    end

endmodule
